spi_ram_master: RTL and testbench
=================================

# spi_ram_master

Host-side SPI master that drives the single-port-RAM SPI slave subsystem (MOSI/SS_n out, MISO in). It accepts one RAM command per request over a valid/ready host interface and serialises it into a slave frame, one bit per `clk` cycle. For read-data commands it deserialises the 8-bit RAM word returned on MISO. It also serves as the reusable stimulus/reference agent for the subsystem's bench.

## Interface
- `TURN_CYC`, default 2: slave turnaround cycles between the last MOSI bit of a read-data frame and the first MISO bit; legal range 1–7.
- `END_CYC`, default 1: minimum cycles SS_n is held high between frames; legal range 1–7.

Ports:
- `clk`  in  1  system clock; all SPI lines are sampled and driven on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  host command valid.
- `req_ready`  out  1  master idle and able to accept a command.
- `req_cmd`  in  2  command: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- `req_data`  in  8  address or data payload; ignored for 11.
- `rsp_valid`  out  1  one-cycle pulse carrying returned read data.
- `rsp_data`  out  8  returned RAM word; held until the next `rsp_valid`.
- `busy`  out  1  frame in progress (SS_n low or end gap active).
- `seq_err`  out  1  one-cycle pulse: read-data request rejected (see Configuration).
- `SS_n`  out  1  slave select, active low.
- `MOSI`  out  1  serial data to slave.
- `MISO`  in  1  serial data from slave.

## Operation
- Reset values: `SS_n`=1, `MOSI`=0, `req_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=0x00, `seq_err`=0, FSM in IDLE.
- Handshake: a command transfers on any cycle with `req_valid && req_ready`. `req_ready` is 1 only in IDLE. `cmd` and `data` are latched into a 10-bit frame {cmd, data}.
- FSM states: IDLE, START, SEL, SHIFT, TURN, RECV, END.
  - IDLE → START on transfer.
  - START (1 cycle): `SS_n`=0, `MOSI`=0.
  - SEL (1 cycle): `MOSI`=cmd[1], the slave's write/read select bit.
  - SHIFT (10 cycles): `MOSI`=frame[9] down to frame[0], MSB first.
  - After SHIFT: cmd 11 goes to TURN; all other commands go to END.
  - TURN (`TURN_CYC` cycles): `MOSI`=0.
  - RECV (8 cycles): sample MISO on each edge, MSB first, into a shift register.
  - END (`END_CYC` cycles): `SS_n`=1, `MOSI`=0; then return to IDLE.
- `rsp_valid` pulses in the first END cycle after a RECV. `rsp_data` updates in the same cycle.
- One 4-bit down-counter serves SHIFT, TURN, RECV and END; it is reloaded on every state entry.
- `SS_n` and `MOSI` are registered (glitch-free).
- Reset asserted mid-frame aborts the frame immediately: `SS_n` goes high asynchronously and no `rsp_valid` is issued.
- `req_valid` held during a frame is not accepted until IDLE. A request presented in the same cycle IDLE is re-entered is accepted.

## Timing
Cycle 0 is the accept cycle; `SS_n` first reads low in cycle 1.
- Write/read-addr frames (00/01/10): `SS_n` low for cycles 1–12 (12 cycles); END at cycle 13; `req_ready`=1 at cycle 13+`END_CYC`.
- Read-data frame (11): `SS_n` low for 12+`TURN_CYC`+8 cycles. With defaults that is cycles 1–22, and MISO is sampled in cycles 15–22.
- `rsp_valid` fires at cycle 23 (defaults).
- Back-to-back throughput: one frame per 13+`END_CYC` cycles, or 21+`TURN_CYC`+`END_CYC` cycles for read-data.

## Configuration
- `SPI_MASTER_SEQ_CHECK_EN` defined:
  - The master tracks a `rd_addr_seen` flag: set by an accepted cmd 10, cleared by an accepted cmd 11 and by reset.
  - A cmd 11 accepted while the flag is clear is not transmitted. `seq_err` pulses in the cycle after acceptance, the FSM stays in IDLE, and no `rsp_valid` is issued.
- Undefined: no tracking; `seq_err` is tied 0 and every cmd 11 is transmitted.

## Structure
- Package `spi_ram_pkg`:
  - `spi_cmd_e` enum: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11.
  - `spi_mst_state_e` enum.
  - Constants FRAME_W=10, DATA_W=8.
- One sub-module, `spi_master_shifter`: a loadable 10-bit TX shift register plus an 8-bit RX shift register, each with a shift enable. The FSM and counter stay in the top level.

## Test plan
- Reset release, then write-addr 0x3C → MOSI over cycles 2–12 = 0,0,0,0,0,1,1,1,1,0,0; `SS_n` low for exactly 12 cycles.
- Write-data 0xA7 immediately followed by a second request → second frame's `SS_n` falls exactly `END_CYC`+1 cycles after the first frame's `SS_n` rises.
- Read-addr 0x3C then read-data, with a slave model driving 0xA5 on MISO in the RECV window → `rsp_valid` for one cycle at cycle 23 of that frame, `rsp_data`=0xA5.
- `rst_n` pulsed low during SHIFT of a read-data frame → `SS_n`=1 and `MOSI`=0 within the reset cycle; no `rsp_valid`; `req_ready`=1 after release.
- Read-data issued with no prior read-addr → with `SPI_MASTER_SEQ_CHECK_EN`: `seq_err` pulse and `SS_n` stays high. Without it: a full 22-cycle frame.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared types and widths for the SPI RAM master: command codes, FSM states and frame geometry.
package spi_ram_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEL,
    ST_SHIFT,
    ST_TURN,
    ST_RECV,
    ST_END
  } spi_mst_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// TX frame shift register (MSB first) and RX deserialiser for the SPI RAM master.
module spi_master_shifter
  import spi_ram_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_load,
  input  logic [FRAME_W-1:0] tx_frame,
  input  logic               tx_shift,
  output logic               tx_msb,
  input  logic               rx_shift,
  input  logic               miso,
  output logic [DATA_W-1:0]  rx_next
);

  logic [FRAME_W-1:0] tx_reg;
  // Seven bits of history suffice: the eighth bit of the word is the live line
  // value on the final RECV edge, which is when the word is captured.
  logic [DATA_W-2:0]  rx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_reg <= '0;
      rx_reg <= '0;
    end else begin
      if (tx_load) begin
        tx_reg <= tx_frame;
      end else if (tx_shift) begin
        tx_reg <= {tx_reg[FRAME_W-2:0], 1'b0};
      end
      if (rx_shift) begin
        rx_reg <= rx_next[DATA_W-2:0];
      end
    end
  end

  assign tx_msb  = tx_reg[FRAME_W-1];
  assign rx_next = {rx_reg, miso};

endmodule

// File: rtl/spi_ram_master.sv
// Host-side SPI master for the single-port-RAM slave. Optional read-data sequence
// checking is enabled by defining SPI_MASTER_SEQ_CHECK_EN.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned END_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              seq_err,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [3:0] SHIFT_LOAD = 4'(FRAME_W - 1);
  localparam logic [3:0] TURN_LOAD  = 4'(TURN_CYC - 1);
  localparam logic [3:0] RECV_LOAD  = 4'(DATA_W - 1);
  localparam logic [3:0] END_LOAD   = 4'(END_CYC - 1);

  spi_mst_state_e    state_reg;
  logic [3:0]        cnt_reg;
  logic              ss_n_reg;
  logic              mosi_reg;
  logic              req_ready_reg;
  logic              busy_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rd_frame_reg;

  logic              accept;
  logic              is_rd_data;
  logic              seq_reject;
  logic              tx_shift;
  logic              rx_shift;
  logic              tx_msb;
  logic [DATA_W-1:0] rx_next;

  assign accept     = req_valid && req_ready_reg;
  assign is_rd_data = (req_cmd == RD_DATA);
  assign tx_shift   = (state_reg == ST_SEL) || (state_reg == ST_SHIFT && cnt_reg != 4'd0);
  assign rx_shift   = (state_reg == ST_RECV);

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic rd_addr_seen_reg;
  logic seq_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_seen_reg <= 1'b0;
      seq_err_reg      <= 1'b0;
    end else begin
      seq_err_reg <= accept && is_rd_data && !rd_addr_seen_reg;
      if (accept && req_cmd == RD_ADDR) begin
        rd_addr_seen_reg <= 1'b1;
      end else if (accept && is_rd_data) begin
        rd_addr_seen_reg <= 1'b0;
      end
    end
  end

  assign seq_reject = is_rd_data && !rd_addr_seen_reg;
  assign seq_err    = seq_err_reg;
`else
  assign seq_reject = 1'b0;
  assign seq_err    = 1'b0;
`endif

  spi_master_shifter u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_load  (accept),
    .tx_frame ({req_cmd, req_data}),
    .tx_shift (tx_shift),
    .tx_msb   (tx_msb),
    .rx_shift (rx_shift),
    .miso     (MISO),
    .rx_next  (rx_next)
  );

  // Every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      ss_n_reg      <= 1'b1;
      mosi_reg      <= 1'b0;
      req_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rd_frame_reg  <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept && !seq_reject) begin
            state_reg     <= ST_START;
            cnt_reg       <= 4'd0;
            ss_n_reg      <= 1'b0;
            mosi_reg      <= 1'b0;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            rd_frame_reg  <= is_rd_data;
          end
        end
        ST_START: begin
          state_reg <= ST_SEL;
          cnt_reg   <= 4'd0;
          mosi_reg  <= tx_msb;
        end
        ST_SEL: begin
          state_reg <= ST_SHIFT;
          cnt_reg   <= SHIFT_LOAD;
          mosi_reg  <= tx_msb;
        end
        ST_SHIFT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg  <= cnt_reg - 4'd1;
            mosi_reg <= tx_msb;
          end else begin
            mosi_reg <= 1'b0;
            if (rd_frame_reg) begin
              state_reg <= ST_TURN;
              cnt_reg   <= TURN_LOAD;
            end else begin
              state_reg <= ST_END;
              cnt_reg   <= END_LOAD;
              ss_n_reg  <= 1'b1;
            end
          end
        end
        ST_TURN: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg <= ST_RECV;
            cnt_reg   <= RECV_LOAD;
          end
        end
        ST_RECV: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg     <= ST_END;
            cnt_reg       <= END_LOAD;
            ss_n_reg      <= 1'b1;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= rx_next;
          end
        end
        ST_END: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          ss_n_reg      <= 1'b1;
          mosi_reg      <= 1'b0;
          req_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = busy_reg;
  assign SS_n      = ss_n_reg;
  assign MOSI      = mosi_reg;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master; cycle 0 of each frame is the accept cycle.
module tb_spi_ram_master;

  localparam int TURN_CYC = 2;
  localparam int END_CYC  = 1;
  localparam int RX0      = 13 + TURN_CYC;
  localparam int RX1      = RX0 + 7;
  localparam int RSP_CYC  = RX1 + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       seq_err;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  int n_cmp = 0;
  int n_err = 0;

  logic       ss_a [0:47];
  logic       mo_a [0:47];
  logic       rv_a [0:47];
  logic       rr_a [0:47];
  logic       se_a [0:47];
  logic       by_a [0:47];
  logic [7:0] rd_a [0:47];

  spi_ram_master #(.TURN_CYC(TURN_CYC), .END_CYC(END_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .seq_err   (seq_err),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [1:0] cmd, input logic [7:0] data);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
    end
    req_cmd   = cmd;
    req_data  = data;
    req_valid = 1'b1;
    $display("txn t=%0t cmd=%b data=0x%02h", $time, cmd, data);
  endtask

  // Records n cycles starting at the accept cycle; slave model drives miso_byte in the RECV window.
  task automatic capture(input int n, input logic [7:0] miso_byte, input int drop_at,
                         input int swap_at, input logic [1:0] cmd2, input logic [7:0] data2);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (k == swap_at) begin
        req_cmd  = cmd2;
        req_data = data2;
      end
      if (k == drop_at) req_valid = 1'b0;
      MISO = (k >= RX0 && k <= RX1) ? miso_byte[RX1 - k] : 1'b1;
      ss_a[k] = SS_n;
      mo_a[k] = MOSI;
      rv_a[k] = rsp_valid;
      rr_a[k] = req_ready;
      se_a[k] = seq_err;
      by_a[k] = busy;
      rd_a[k] = rsp_data;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 2'b00; req_data = 8'h00; MISO = 1'b1;
    repeat (3) @(negedge clk);
    if (SS_n !== 1'b1) begin n_err++; $display("FAIL reset_ss_n: got %b want 1", SS_n); end
    n_cmp++;
    if (MOSI !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b want 0", MOSI); end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++;
    if (rsp_data !== 8'h00) begin n_err++; $display("FAIL reset_rsp_data: got %02h want 00", rsp_data); end
    n_cmp++;
    if (seq_err !== 1'b0) begin n_err++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    n_cmp++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_addr;
    logic [10:0] mv;
    int low;
    issue(2'b00, 8'h3C);
    capture(18, 8'h00, 1, -1, 2'b00, 8'h00);
    for (int k = 2; k <= 12; k++) mv[12 - k] = mo_a[k];
    if (mv !== 11'b00000111100) begin n_err++; $display("FAIL wa_mosi: got %b want 00000111100", mv); end
    n_cmp++;
    low = 0;
    for (int k = 0; k < 18; k++) if (ss_a[k] === 1'b0) low++;
    if (low != 12 || ss_a[1] !== 1'b0 || ss_a[13] !== 1'b1) begin
      n_err++; $display("FAIL wa_ss_window: low=%0d ss[1]=%b ss[13]=%b want 12,0,1", low, ss_a[1], ss_a[13]);
    end
    n_cmp++;
    if (rr_a[13] !== 1'b0 || rr_a[13 + END_CYC] !== 1'b1) begin
      n_err++; $display("FAIL wa_ready: ready[13]=%b ready[14]=%b want 0,1", rr_a[13], rr_a[13 + END_CYC]);
    end
    n_cmp++;
    if (by_a[13] !== 1'b1 || by_a[1] !== 1'b1) begin
      n_err++; $display("FAIL wa_busy: busy[1]=%b busy[13]=%b want 1,1", by_a[1], by_a[13]);
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back;
    logic [10:0] mv1, mv2;
    int r, f;
    issue(2'b01, 8'hA7);
    capture(32, 8'h00, 13 + END_CYC + 1, 1, 2'b00, 8'h55);
    $display("txn t=%0t cmd=00 data=0x55 (held during previous frame)", $time);
    r = -1; f = -1;
    for (int k = 1; k < 32; k++) begin
      if (r < 0 && ss_a[k - 1] === 1'b0 && ss_a[k] === 1'b1) r = k;
      else if (r >= 0 && f < 0 && ss_a[k] === 1'b0) f = k;
    end
    if (r != 13 || f - r != END_CYC + 1) begin
      n_err++; $display("FAIL b2b_gap: rise=%0d fall=%0d want 13,%0d", r, f, 13 + END_CYC + 1);
    end
    n_cmp++;
    for (int k = 2; k <= 12; k++) mv1[12 - k] = mo_a[k];
    for (int k = 16; k <= 26; k++) mv2[26 - k] = mo_a[k];
    if (mv1 !== 11'b00110100111) begin n_err++; $display("FAIL b2b_mosi1: got %b want 00110100111", mv1); end
    n_cmp++;
    if (mv2 !== 11'b00001010101) begin n_err++; $display("FAIL b2b_mosi2: got %b want 00001010101", mv2); end
    n_cmp++;
  endtask

  task automatic test_read;
    int low, nrv;
    issue(2'b10, 8'h3C);
    capture(16, 8'h00, 1, -1, 2'b00, 8'h00);
    if (mo_a[2] !== 1'b1) begin n_err++; $display("FAIL ra_sel_bit: got %b want 1", mo_a[2]); end
    n_cmp++;
    issue(2'b11, 8'h00);
    capture(30, 8'hA5, 1, -1, 2'b00, 8'h00);
    low = 0; nrv = 0;
    for (int k = 0; k < 30; k++) begin
      if (ss_a[k] === 1'b0) low++;
      if (rv_a[k] === 1'b1) nrv++;
    end
    if (low != 22 || ss_a[22] !== 1'b0 || ss_a[23] !== 1'b1) begin
      n_err++; $display("FAIL rd_ss_window: low=%0d ss[22]=%b ss[23]=%b want 22,0,1", low, ss_a[22], ss_a[23]);
    end
    n_cmp++;
    if (rv_a[RSP_CYC] !== 1'b1 || nrv != 1) begin
      n_err++; $display("FAIL rd_rsp_valid: at23=%b pulses=%0d want 1,1", rv_a[RSP_CYC], nrv);
    end
    n_cmp++;
    if (rd_a[RSP_CYC] !== 8'hA5 || rd_a[29] !== 8'hA5) begin
      n_err++; $display("FAIL rd_rsp_data: at23=%02h at29=%02h want a5", rd_a[RSP_CYC], rd_a[29]);
    end
    n_cmp++;
    if (mo_a[13] !== 1'b0 || mo_a[14] !== 1'b0 || mo_a[2] !== 1'b1) begin
      n_err++; $display("FAIL rd_mosi_turn: sel=%b t13=%b t14=%b want 1,0,0", mo_a[2], mo_a[13], mo_a[14]);
    end
    n_cmp++;
  endtask

  task automatic test_reset_abort;
    int nrv, low;
    issue(2'b10, 8'h12);
    capture(16, 8'h00, 1, -1, 2'b00, 8'h00);
    issue(2'b11, 8'h00);
    capture(6, 8'hFF, 1, -1, 2'b00, 8'h00);
    @(negedge clk);
    if (SS_n !== 1'b0) begin n_err++; $display("FAIL abort_pre_ss: got %b want 0", SS_n); end
    n_cmp++;
    rst_n = 1'b0;
    #1;
    if (SS_n !== 1'b1 || MOSI !== 1'b0) begin
      n_err++; $display("FAIL abort_lines: ss_n=%b mosi=%b want 1,0", SS_n, MOSI);
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0; low = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) nrv++;
      if (SS_n === 1'b0) low++;
    end
    if (nrv != 0 || low != 0) begin
      n_err++; $display("FAIL abort_quiet: rsp_valid pulses=%0d ss low=%0d want 0,0", nrv, low);
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    n_cmp++;
  endtask

  task automatic test_seq;
    int low, nrv, nse;
    issue(2'b11, 8'h00);
    capture(30, 8'h3C, 1, -1, 2'b00, 8'h00);
    low = 0; nrv = 0; nse = 0;
    for (int k = 0; k < 30; k++) begin
      if (ss_a[k] === 1'b0) low++;
      if (rv_a[k] === 1'b1) nrv++;
      if (se_a[k] === 1'b1) nse++;
    end
`ifdef SPI_MASTER_SEQ_CHECK_EN
    if (se_a[1] !== 1'b1 || nse != 1) begin
      n_err++; $display("FAIL seq_err_pulse: at1=%b pulses=%0d want 1,1", se_a[1], nse);
    end
    n_cmp++;
    if (low != 0 || nrv != 0 || rr_a[1] !== 1'b1) begin
      n_err++; $display("FAIL seq_no_frame: ss low=%0d rsp=%0d ready1=%b want 0,0,1", low, nrv, rr_a[1]);
    end
    n_cmp++;
`else
    if (nse != 0 || low != 22) begin
      n_err++; $display("FAIL seq_frame: seq_err pulses=%0d ss low=%0d want 0,22", nse, low);
    end
    n_cmp++;
    if (rv_a[RSP_CYC] !== 1'b1 || rd_a[RSP_CYC] !== 8'h3C) begin
      n_err++; $display("FAIL seq_rsp: valid=%b data=%02h want 1,3c", rv_a[RSP_CYC], rd_a[RSP_CYC]);
    end
    n_cmp++;
`endif
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_back_to_back();
    test_read();
    test_reset_abort();
    test_seq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
